// File: rtl/mult_arb_pkg.sv
// Shared types, default parameters and the round-robin pick function for mult_arbiter.
package mult_arb_pkg;

    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

    localparam int unsigned DEF_N_REQ = 2;
    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_CNT_W = 16;

    // First valid index strictly after last, wrapping modulo n (n <= 8).
    function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] last,
                                           input int unsigned n);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= 8; i++) begin
            idx = (32'(last) + i) % n;
            if (!found && i <= n && valid[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mult_core.sv
// Combinational unsigned WIDTH x WIDTH multiplier producing the full 2*WIDTH-bit product.
module mult_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] y
);

    assign y = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier between N_REQ requesters (IDLE -> MUL -> RESP).
// Optional per-requester grant counters are built when MULT_ARB_STATS_EN is defined.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_a,
    input  logic [N_REQ*WIDTH-1:0]     req_b,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       resp_valid,
    output logic [2*WIDTH-1:0]         resp_y,
    output logic [$clog2(N_REQ)-1:0]   resp_id,
    input  logic                       resp_ready,
    output logic [N_REQ*CNT_W-1:0]     grant_cnt
);

    localparam int unsigned ID_W = $clog2(N_REQ);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    last_q, id_q, pick;
    logic [WIDTH-1:0]   a_q, b_q, a_sel, b_sel;
    logic [2*WIDTH-1:0] y_q, prod;
    logic [N_REQ-1:0]   grant;
    logic               hs;

    always_comb begin
        pick  = ID_W'(rr_pick(8'(req_valid), 3'(last_q), N_REQ));
        a_sel = req_a[pick*WIDTH +: WIDTH];
        b_sel = req_b[pick*WIDTH +: WIDTH];
    end

    // Grant is gated by reset so no port sees ready while reset is held.
    always_comb begin
        state_d = state_q;
        grant   = '0;
        case (state_q)
            IDLE: begin
                if (reset && |req_valid) begin
                    grant[pick] = 1'b1;
                end
                if (hs) begin
                    state_d = MUL;
                end
            end
            MUL:     state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign hs         = |(req_valid & grant);
    assign req_ready  = grant;
    assign resp_valid = (state_q == RESP);
    assign resp_y     = y_q;
    assign resp_id    = id_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= ID_W'(N_REQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                last_q <= pick;
                id_q   <= pick;
                a_q    <= a_sel;
                b_q    <= b_sel;
            end
            if (state_q == MUL) begin
                y_q <= prod;
            end
        end
    end

    mult_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a(a_q),
        .b(b_q),
        .y(prod)
    );

`ifdef MULT_ARB_STATS_EN
    for (genvar i = 0; i < int'(N_REQ); i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
            end else if (req_valid[i] && grant[i] && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
        assign grant_cnt[i*CNT_W +: CNT_W] = cnt_q;
    end
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed steps with an expected-response queue.
module tb_mult_arbiter;

    localparam int unsigned N = 2;
    localparam int unsigned W = 4;
    localparam int unsigned C = 16;

    logic             clk;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a, req_b;
    logic [N-1:0]     req_ready;
    logic             resp_valid;
    logic [2*W-1:0]   resp_y;
    logic [0:0]       resp_id;
    logic             resp_ready;
    logic [N*C-1:0]   grant_cnt;

    int checks   = 0;
    int failures = 0;
    logic [8:0] exp_q[$];

    mult_arbiter #(
        .N_REQ(N),
        .WIDTH(W),
        .CNT_W(C)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_a(req_a),
        .req_b(req_b),
        .req_ready(req_ready),
        .resp_valid(resp_valid),
        .resp_y(resp_y),
        .resp_id(resp_id),
        .resp_ready(resp_ready),
        .grant_cnt(grant_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int id, input int a, input int b);
        logic [8:0] e;
        e = {1'(id), 8'(a * b)};
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        logic [8:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_y"}, 32'(resp_y), 32'(e[7:0]));
            check({tag, "_id"}, 32'(resp_id), 32'(e[8]));
        end
    endtask

    // Bounded wait for resp_valid; a timeout counts as a failure.
    task automatic wait_resp(input string tag);
        int n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_rv"}, 32'(resp_valid), 32'd1);
    endtask

    task automatic set_op(input int port, input int a, input int b);
        req_a[port*W +: W] = W'(a);
        req_b[port*W +: W] = W'(b);
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 2'b11;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;

        // 1. reset with both valid
        step();
        step();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rv", 32'(resp_valid), 32'd0);
        check("rst_y", 32'(resp_y), 32'd0);
        check("rst_id", 32'(resp_id), 32'd0);
        check("rst_cnt", grant_cnt, 32'd0);
        req_valid = 2'b00;
        reset     = 1'b1;
        step();

        // 2. max*max on req0, latency T+2
        set_op(0, 15, 15);
        req_valid = 2'b01;
        #1;
        check("t2_ready", 32'(req_ready), 32'd1);
        push_exp(0, 15, 15);
        step();
        req_valid = 2'b00;
        check("t2_rv_t1", 32'(resp_valid), 32'd0);
        step();
        check("t2_rv_t2", 32'(resp_valid), 32'd1);
        pop_check("t2");
        check("t2_y_e1", 32'(resp_y), 32'hE1);
        step();
        check("t2_rv_drop", 32'(resp_valid), 32'd0);

        // 3. continuous valid on both: strict alternation from requester 0 after reset
        reset = 1'b0;
        #1;
        reset = 1'b1;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            set_op(0, k + 1, k + 3);
            set_op(1, 15 - k, k + 7);
            #1;
            check("t3_grant", 32'(req_ready), 32'(1 << (k % 2)));
            if (k % 2 == 0) push_exp(0, k + 1, k + 3);
            else push_exp(1, 15 - k, k + 7);
            step();
            check("t3_mul_ready", 32'(req_ready), 32'd0);
            step();
            check("t3_rv", 32'(resp_valid), 32'd1);
            pop_check("t3");
            step();
        end
        req_valid = 2'b00;

        // 4. backpressure: held response, no grants
        resp_ready = 1'b0;
        set_op(0, 10, 11);
        req_valid = 2'b01;
        push_exp(0, 10, 11);
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            check("t4_rv", 32'(resp_valid), 32'd1);
            check("t4_y", 32'(resp_y), 32'h6E);
            check("t4_id", 32'(resp_id), 32'd0);
            check("t4_ready", 32'(req_ready), 32'd0);
            step();
        end
        req_valid  = 2'b00;
        resp_ready = 1'b1;
        pop_check("t4");
        step();
        check("t4_rv_drop", 32'(resp_valid), 32'd0);

        // 5. reset during MUL drops the transaction
        set_op(1, 5, 6);
        req_valid = 2'b10;
        #1;
        check("t5_grant", 32'(req_ready), 32'd2);
        step();
        req_valid = 2'b00;
        reset     = 1'b0;
        #1;
        check("t5_rv_rst", 32'(resp_valid), 32'd0);
        check("t5_ready_rst", 32'(req_ready), 32'd0);
        step();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("t5_no_resp", 32'(resp_valid), 32'd0);
        end

        // 6. full operand sweep through requester 1
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                set_op(1, a, b);
                req_valid = 2'b10;
                push_exp(1, a, b);
                step();
                req_valid = 2'b00;
                wait_resp("t6");
                pop_check("t6");
                step();
            end
        end
`ifdef MULT_ARB_STATS_EN
        check("t6_cnt1", 32'(grant_cnt[C +: C]), 32'd256);
        check("t6_cnt0", 32'(grant_cnt[0 +: C]), 32'd0);
`else
        check("t6_cnt_off", grant_cnt, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
